// File: rtl/score_board.sv
// Pong score keeper: detects the ball leaving either side of the screen, keeps
// saturating BCD scores per player, and sequences play / hold / game-over.
module score_board #(
    parameter int unsigned DIGITS     = 2,
    parameter int unsigned X_W        = 10,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned WIN_POINTS = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [X_W-1:0]        ball_x,
    input  logic [5:0]            ball_width,
    input  logic                  serve,
    input  logic                  new_game,
    output logic [4*DIGITS-1:0]   score_l,
    output logic [4*DIGITS-1:0]   score_r,
    output logic                  point_l,
    output logic                  point_r,
    output logic                  game_over,
    output logic                  winner,
    output logic                  serve_dir,
    output logic [1:0]            state
);

    localparam int unsigned SC_W    = 4 * DIGITS;
    localparam int unsigned MAX_CNT = (10 ** DIGITS) - 1;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned ZW      = X_W + 1;

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_HOLD = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t            r_state, w_state_n;
    logic              r_zl, r_zr;
    logic [SC_W-1:0]   r_score_l, r_score_r, w_score_l_n, w_score_r_n;
    logic [CNT_W-1:0]  r_cnt_l, r_cnt_r, w_cnt_l_n, w_cnt_r_n;
    logic [CNT_W-1:0]  w_cnt_l_inc, w_cnt_r_inc;
    logic              r_point_l, r_point_r, w_point_l_n, w_point_r_n;
    logic              r_winner, w_winner_n;
    logic              r_serve_dir, w_serve_dir_n;
    logic [ZW-1:0]     w_thr;
    logic              w_zl, w_zr, w_ev_l, w_ev_r;
    logic              w_win_l, w_win_r;

    // Add one to a BCD value, rippling the carry through nines.
    function automatic logic [SC_W-1:0] bcd_inc(input logic [SC_W-1:0] v);
        logic [SC_W-1:0] res;
        logic            carry;
        res   = v;
        carry = 1'b1;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (carry) begin
                if (v[4*d +: 4] == 4'd9) begin
                    res[4*d +: 4] = 4'd0;
                end else begin
                    res[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Right-zone threshold; a non-positive threshold means the ball always touches the edge.
    assign w_thr  = ZW'(SCREEN_W - 1) - ZW'(ball_width);
    assign w_zr   = w_thr[ZW-1] || (w_thr == '0) || (ZW'(ball_x) >= w_thr);
    assign w_zl   = (ball_x == '0);
    assign w_ev_l = w_zl && !r_zl;
    assign w_ev_r = w_zr && !r_zr;

    assign w_cnt_l_inc = (r_cnt_l == CNT_W'(MAX_CNT)) ? r_cnt_l : r_cnt_l + CNT_W'(1);
    assign w_cnt_r_inc = (r_cnt_r == CNT_W'(MAX_CNT)) ? r_cnt_r : r_cnt_r + CNT_W'(1);
    assign w_win_l     = (WIN_POINTS != 0) && (32'(w_cnt_l_inc) == WIN_POINTS);
    assign w_win_r     = (WIN_POINTS != 0) && (32'(w_cnt_r_inc) == WIN_POINTS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_PLAY;
            r_zl        <= 1'b1;
            r_zr        <= 1'b1;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_cnt_l     <= '0;
            r_cnt_r     <= '0;
            r_point_l   <= 1'b0;
            r_point_r   <= 1'b0;
            r_winner    <= 1'b0;
            r_serve_dir <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_zl        <= w_zl;
            r_zr        <= w_zr;
            r_score_l   <= w_score_l_n;
            r_score_r   <= w_score_r_n;
            r_cnt_l     <= w_cnt_l_n;
            r_cnt_r     <= w_cnt_r_n;
            r_point_l   <= w_point_l_n;
            r_point_r   <= w_point_r_n;
            r_winner    <= w_winner_n;
            r_serve_dir <= w_serve_dir_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_score_l_n   = r_score_l;
        w_score_r_n   = r_score_r;
        w_cnt_l_n     = r_cnt_l;
        w_cnt_r_n     = r_cnt_r;
        w_point_l_n   = 1'b0;
        w_point_r_n   = 1'b0;
        w_winner_n    = r_winner;
        w_serve_dir_n = r_serve_dir;
        if (new_game) begin
            w_state_n   = S_PLAY;
            w_score_l_n = '0;
            w_score_r_n = '0;
            w_cnt_l_n   = '0;
            w_cnt_r_n   = '0;
        end else begin
            case (r_state)
                S_PLAY: begin
                    // Simultaneous exits on both sides are treated as no point.
                    if (w_ev_r && !w_ev_l) begin
                        w_point_l_n   = 1'b1;
                        w_cnt_l_n     = w_cnt_l_inc;
                        w_score_l_n   = (r_cnt_l == CNT_W'(MAX_CNT)) ? r_score_l : bcd_inc(r_score_l);
                        w_serve_dir_n = 1'b1;
                        if (w_win_l) begin
                            w_state_n  = S_OVER;
                            w_winner_n = 1'b0;
                        end else begin
                            w_state_n  = S_HOLD;
                        end
                    end else if (w_ev_l && !w_ev_r) begin
                        w_point_r_n   = 1'b1;
                        w_cnt_r_n     = w_cnt_r_inc;
                        w_score_r_n   = (r_cnt_r == CNT_W'(MAX_CNT)) ? r_score_r : bcd_inc(r_score_r);
                        w_serve_dir_n = 1'b0;
                        if (w_win_r) begin
                            w_state_n  = S_OVER;
                            w_winner_n = 1'b1;
                        end else begin
                            w_state_n  = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (serve && !w_zl && !w_zr) begin
                        w_state_n = S_PLAY;
                    end
                end
                S_OVER: begin
                    w_state_n = S_OVER;
                end
                default: begin
                    w_state_n = S_PLAY;
                end
            endcase
        end
    end

    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign point_l   = r_point_l;
    assign point_r   = r_point_r;
    assign winner    = r_winner;
    assign serve_dir = r_serve_dir;
    assign state     = r_state;
    assign game_over = (r_state == S_OVER);

endmodule

// File: tb/tb_score_board.sv
// Bench for score_board: two instances (640-wide with win at 11, 8-wide with no win
// limit) share stimulus and are compared each cycle against an integer-level model.
module tb_score_board;

    logic       clk;
    logic       reset;
    logic [9:0] ball_x;
    logic [5:0] ball_width;
    logic       serve;
    logic       new_game;

    logic [7:0] a_score_l, a_score_r, b_score_l, b_score_r;
    logic       a_point_l, a_point_r, a_game_over, a_winner, a_serve_dir;
    logic       b_point_l, b_point_r, b_game_over, b_winner, b_serve_dir;
    logic [1:0] a_state, b_state;

    int n_checks;
    int n_err;

    int m_sw [2];
    int m_win[2];
    int m_cl [2];
    int m_cr [2];
    int m_st [2];
    bit m_pl [2];
    bit m_pr [2];
    bit m_winner[2];
    bit m_sdir[2];
    bit m_pzl[2];
    bit m_pzr[2];

    score_board #(.DIGITS(2), .X_W(10), .SCREEN_W(640), .WIN_POINTS(11)) u_a (
        .clk(clk), .reset(reset), .ball_x(ball_x), .ball_width(ball_width),
        .serve(serve), .new_game(new_game),
        .score_l(a_score_l), .score_r(a_score_r), .point_l(a_point_l), .point_r(a_point_r),
        .game_over(a_game_over), .winner(a_winner), .serve_dir(a_serve_dir), .state(a_state)
    );

    score_board #(.DIGITS(2), .X_W(10), .SCREEN_W(8), .WIN_POINTS(0)) u_b (
        .clk(clk), .reset(reset), .ball_x(ball_x), .ball_width(ball_width),
        .serve(serve), .new_game(new_game),
        .score_l(b_score_l), .score_r(b_score_r), .point_l(b_point_l), .point_r(b_point_r),
        .game_over(b_game_over), .winner(b_winner), .serve_dir(b_serve_dir), .state(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cl[i] = 0;  m_cr[i] = 0;  m_st[i] = 0;
            m_pl[i] = 0;  m_pr[i] = 0;
            m_winner[i] = 0;  m_sdir[i] = 0;
            m_pzl[i] = 1; m_pzr[i] = 1;
        end
    endtask

    // One clock edge of the game rules, applied to the current inputs.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit zl, zr, evl, evr;
            int thr;
            zl  = (ball_x == 10'd0);
            thr = m_sw[i] - 1 - int'(ball_width);
            zr  = (thr <= 0) ? 1'b1 : (int'(ball_x) >= thr);
            evl = zl && !m_pzl[i];
            evr = zr && !m_pzr[i];
            m_pzl[i] = zl;
            m_pzr[i] = zr;
            m_pl[i]  = 0;
            m_pr[i]  = 0;
            if (new_game) begin
                m_cl[i] = 0; m_cr[i] = 0; m_st[i] = 0;
            end else if (m_st[i] == 0) begin
                if (evr && !evl) begin
                    m_pl[i] = 1;
                    if (m_cl[i] < 99) m_cl[i]++;
                    m_sdir[i] = 1;
                    if (m_win[i] != 0 && m_cl[i] == m_win[i]) begin
                        m_st[i] = 2; m_winner[i] = 0;
                    end else m_st[i] = 1;
                end else if (evl && !evr) begin
                    m_pr[i] = 1;
                    if (m_cr[i] < 99) m_cr[i]++;
                    m_sdir[i] = 0;
                    if (m_win[i] != 0 && m_cr[i] == m_win[i]) begin
                        m_st[i] = 2; m_winner[i] = 1;
                    end else m_st[i] = 1;
                end
            end else if (m_st[i] == 1) begin
                if (serve && !zl && !zr) m_st[i] = 0;
            end
        end
    endtask

    task automatic check_one(input string n, input int i,
                             input logic [7:0] sl, input logic [7:0] sr,
                             input logic pl, input logic pr, input logic go,
                             input logic wn, input logic sd, input logic [1:0] st);
        check({n, ".score_l"},   sl,        to_bcd(m_cl[i]));
        check({n, ".score_r"},   sr,        to_bcd(m_cr[i]));
        check({n, ".point_l"},   8'(pl),    8'(m_pl[i]));
        check({n, ".point_r"},   8'(pr),    8'(m_pr[i]));
        check({n, ".game_over"}, 8'(go),    8'(m_st[i] == 2));
        check({n, ".winner"},    8'(wn),    8'(m_winner[i]));
        check({n, ".serve_dir"}, 8'(sd),    8'(m_sdir[i]));
        check({n, ".state"},     8'(st),    8'(m_st[i]));
    endtask

    task automatic check_all();
        check_one("a", 0, a_score_l, a_score_r, a_point_l, a_point_r, a_game_over, a_winner, a_serve_dir, a_state);
        check_one("b", 1, b_score_l, b_score_r, b_point_l, b_point_r, b_game_over, b_winner, b_serve_dir, b_state);
    endtask

    task automatic step(input logic [9:0] x, input logic [5:0] w, input logic s, input logic ng);
        ball_x     = x;
        ball_width = w;
        serve      = s;
        new_game   = ng;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        m_sw[0]  = 640; m_sw[1]  = 8;
        m_win[0] = 11;  m_win[1] = 0;

        // Reset and defaults
        reset = 1'b1; ball_x = 10'd300; ball_width = 6'd8; serve = 1'b0; new_game = 1'b0;
        model_reset();
        #3;
        check_all();
        check("defaults.a.state", 8'(a_state), 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // First point for the left player, then 20 held cycles
        step(10'd600, 6'd8, 1'b0, 1'b0);
        step(10'd631, 6'd8, 1'b0, 1'b0);
        check("first_pt.score_l", a_score_l, 8'h01);
        check("first_pt.point_l", 8'(a_point_l), 8'd1);
        for (int k = 0; k < 20; k++) begin
            step(10'd631, 6'd8, 1'b0, 1'b0);
            check("held.point_l", 8'(a_point_l), 8'd0);
        end
        check("held.state", 8'(a_state), 8'd1);
        check("held.score_l", a_score_l, 8'h01);

        // BCD carry 09 -> 10
        for (int k = 2; k <= 9; k++) begin
            step(10'd300, 6'd8, 1'b1, 1'b0);
            step(10'd631, 6'd8, 1'b0, 1'b0);
        end
        check("bcd.score_l_09", a_score_l, 8'h09);
        step(10'd300, 6'd8, 1'b1, 1'b0);
        step(10'd631, 6'd8, 1'b0, 1'b0);
        check("bcd.score_l_10", a_score_l, 8'h10);

        // Saturation at 99 on the narrow instance; new_game beats a same-cycle exit
        step(10'd0, 6'd8, 1'b0, 1'b1);
        check("ng_prio.point_r", 8'(a_point_r), 8'd0);
        for (int k = 0; k < 99; k++) begin
            step(10'd3, 6'd0, 1'b1, 1'b0);
            step(10'd7, 6'd0, 1'b0, 1'b0);
        end
        check("sat.score_l_99", b_score_l, 8'h99);
        step(10'd3, 6'd0, 1'b1, 1'b0);
        step(10'd7, 6'd0, 1'b0, 1'b0);
        check("sat.score_hold", b_score_l, 8'h99);
        check("sat.point_l", 8'(b_point_l), 8'd1);
        step(10'd7, 6'd0, 1'b0, 1'b0);
        check("sat.point_l_drop", 8'(b_point_l), 8'd0);

        // Right player wins at 11
        step(10'd300, 6'd8, 1'b0, 1'b1);
        for (int k = 0; k < 11; k++) begin
            step(10'd300, 6'd8, 1'b1, 1'b0);
            step(10'd0, 6'd8, 1'b0, 1'b0);
        end
        check("win.game_over", 8'(a_game_over), 8'd1);
        check("win.winner", 8'(a_winner), 8'd1);
        check("win.state", 8'(a_state), 8'd2);
        check("win.score_r", a_score_r, 8'h11);
        step(10'd300, 6'd8, 1'b1, 1'b0);
        check("over.serve_ignored", 8'(a_state), 8'd2);
        step(10'd0, 6'd8, 1'b0, 1'b0);
        check("over.no_score", a_score_r, 8'h11);
        step(10'd300, 6'd8, 1'b0, 1'b1);
        check("newgame.score_l", a_score_l, 8'h00);
        check("newgame.score_r", a_score_r, 8'h00);
        check("newgame.state", 8'(a_state), 8'd0);

        // Serve refused while ball still in a zone
        step(10'd0, 6'd8, 1'b0, 1'b0);
        check("hold.enter", 8'(a_state), 8'd1);
        step(10'd0, 6'd8, 1'b1, 1'b0);
        check("hold.in_zone", 8'(a_state), 8'd1);
        step(10'd300, 6'd8, 1'b1, 1'b0);
        check("hold.serve", 8'(a_state), 8'd0);

        // Reset asserted as the ball reaches the left edge
        step(10'd300, 6'd8, 1'b0, 1'b0);
        ball_x = 10'd0;
        reset  = 1'b1;
        model_reset();
        #1;
        check_all();
        check("rst.async_score_r", a_score_r, 8'h00);
        @(posedge clk); #1;
        check_all();
        check("rst.point_r", 8'(a_point_r), 8'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(10'd0, 6'd8, 1'b0, 1'b0);
            check("rst_release.point_r", 8'(a_point_r), 8'd0);
        end

        // Coincident exits on the 8-pixel screen
        step(10'd3, 6'd0, 1'b0, 1'b0);
        step(10'd0, 6'd7, 1'b0, 1'b0);
        check("coinc.point_l", 8'(b_point_l), 8'd0);
        check("coinc.point_r", 8'(b_point_r), 8'd0);
        check("coinc.state", 8'(b_state), 8'd0);

        // Randomised play
        for (int n = 0; n < 600; n++) begin
            logic [9:0] x;
            logic [5:0] w;
            int         sel;
            sel = int'($urandom_range(0, 7));
            case (sel)
                0, 1: x = 10'd0;
                2:    x = 10'd631;
                3:    x = 10'd639;
                4:    x = 10'd7;
                5:    x = 10'd3;
                6:    x = 10'd300;
                default: x = 10'($urandom_range(0, 700));
            endcase
            w = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd8;
            step(x, w, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
